// File: rtl/rom_stream_pkg.sv
// Shared types and constants for the ROM read sequencer and its output FIFO.
package rom_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/rom_streamer_fifo2.sv
// Two-entry FIFO holding ROM words plus their end-of-burst flag.
module stream_fifo2
    import rom_stream_pkg::*;
#(
    parameter int Width = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] din,
    input  logic             pop,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem [FIFO_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       level;
    logic             wr_en;
    logic             rd_en;

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign full  = (level == 2'(FIFO_DEPTH));
    assign empty = (level == 2'd0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            level  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/rom_streamer.sv
// Burst read sequencer: walks a wrapping ROM address range and streams the
// returned words out over valid/ready with credit-based flow control.
module rom_streamer
    import rom_stream_pkg::*;
#(
    parameter int Data_Width = 8,
    parameter int Addr_Width = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [Addr_Width-1:0] base_addr,
    input  logic [Addr_Width:0]   count,
    output logic [Addr_Width-1:0] rom_addr,
    input  logic [Data_Width-1:0] rom_dout,
    output logic [Data_Width-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    state_t                state;
    state_t                next_state;
    logic [Addr_Width:0]   burst_count;
    logic [Addr_Width:0]   issued;
    logic [Addr_Width:0]   issued_next;
    logic                  inflight;
    logic                  inflight_last;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [Data_Width:0]   fifo_dout;
    logic [1:0]            occupancy;
    logic                  pop;
    logic                  credit_ok;
    logic                  issue;
    logic                  load;
    logic                  zero_start;
    logic                  finish;

    assign pop         = m_valid && m_ready;
    assign m_valid     = !fifo_empty;
    assign m_data      = fifo_dout[Data_Width-1:0];
    assign m_last      = fifo_dout[Data_Width] && !fifo_empty;
    assign busy        = (state != IDLE);
    assign occupancy   = {fifo_full, !fifo_full && !fifo_empty};
    assign issued_next = issued + (Addr_Width + 1)'(1);

    // Entries leaving on this edge free their slot immediately, which keeps
    // one word per clock flowing while never overcommitting the FIFO.
    assign credit_ok = ((occupancy - {1'b0, pop} + {1'b0, inflight}) < 2'(FIFO_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        load       = 1'b0;
        zero_start = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        load       = 1'b1;
                        next_state = FETCH;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (issued_next == burst_count) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Each issued address lands in the FIFO exactly one edge later, tagged with its last flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr      <= '0;
            burst_count   <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (load) begin
                rom_addr    <= base_addr;
                burst_count <= count;
                issued      <= '0;
            end else if (issue) begin
                rom_addr <= rom_addr + Addr_Width'(1);
                issued   <= issued_next;
            end
            inflight      <= issue;
            inflight_last <= issue && (issued_next == burst_count);
            done          <= zero_start || finish;
        end
    end

    stream_fifo2 #(
        .Width(Data_Width + 1)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (inflight),
        .din  ({inflight_last, rom_dout}),
        .pop  (pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

endmodule

// File: tb/tb_rom_streamer.sv
// Scoreboard bench for rom_streamer: a behavioural ROM, an expected-beat queue
// filled at each accepted start, and a negedge monitor draining it.
module tb_rom_streamer;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] romMem [DEPTH];
    beat_t         expQ [$];
    int            vectors = 0;
    int            miscompares = 0;
    int            beatCount = 0;
    bit            randomReady = 1'b0;
    bit            lastSeen = 1'b0;
    bit            stallPrev = 1'b0;
    logic [DW-1:0] heldData;
    logic          heldLast;

    rom_streamer #(
        .Data_Width(DW),
        .Addr_Width(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .count    (count),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // One-cycle registered ROM, as the sequencer expects.
    always @(posedge clk) rom_dout <= romMem[rom_addr];

    // Consumer ready: held high unless a test asks for a random stall pattern.
    always @(posedge clk) begin
        #1;
        m_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Issue a start; when the burst should be accepted, queue its expected beats.
    task automatic applyStimulus(input int base, input int cnt, input bit expectAccept);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = AW'(base);
        count     = (AW + 1)'(cnt);
        if (expectAccept) begin
            for (int i = 0; i < cnt; i++) begin
                expQ.push_back('{data: romMem[(base + i) % DEPTH], last: (i == cnt - 1)});
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        checkOutput("done_seen", done, 1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Monitor: scoreboard pops, stall stability, and done/busy after the last handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (lastSeen) begin
                checkOutput("done_after_last", done, 1);
                checkOutput("busy_after_last", busy, 0);
                lastSeen = 1'b0;
            end
            if (stallPrev) begin
                checkOutput("stall_valid", m_valid, 1);
                checkOutput("stall_data", m_data, heldData);
                checkOutput("stall_last", m_last, heldLast);
            end
            stallPrev = m_valid && !m_ready;
            heldData  = m_data;
            heldLast  = m_last;
            if (m_valid && m_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", m_valid, 0);
                end else begin
                    beat_t exp;
                    exp = expQ.pop_front();
                    checkOutput("beat_data", m_data, exp.data);
                    checkOutput("beat_last", m_last, exp.last);
                    beatCount++;
                    if (m_last) lastSeen = 1'b1;
                end
            end
        end
    end

    initial begin
        int b;
        int target;
        for (int i = 0; i < DEPTH; i++) romMem[i] = DW'($urandom);

        // Reset state
        #1;
        checkOutput("reset_rom_addr", rom_addr, 0);
        checkOutput("reset_m_valid", m_valid, 0);
        checkOutput("reset_m_data", m_data, 0);
        checkOutput("reset_m_last", m_last, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(2);

        // Basic burst with first-beat latency
        applyStimulus(3, 5, 1'b1);
        @(negedge clk);
        checkOutput("lat_e0_valid", m_valid, 0);
        checkOutput("lat_e0_addr", rom_addr, 3);
        checkOutput("lat_e0_busy", busy, 1);
        @(negedge clk);
        checkOutput("lat_e1_valid", m_valid, 0);
        @(negedge clk);
        checkOutput("lat_e2_valid", m_valid, 1);
        waitDone(20);
        idleCycles(2);

        // Wrapping burst, address sequence
        applyStimulus(14, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("wrap_addr", rom_addr, (14 + i) % DEPTH);
        end
        waitDone(20);
        idleCycles(2);

        // Full-depth burst under random backpressure
        randomReady = 1'b1;
        applyStimulus(int'($urandom_range(0, DEPTH - 1)), DEPTH, 1'b1);
        waitDone(300);
        randomReady = 1'b0;
        idleCycles(3);

        // Zero-length request
        applyStimulus(5, 0, 1'b1);
        checkOutput("zero_done", done, 1);
        checkOutput("zero_busy", busy, 0);
        checkOutput("zero_valid", m_valid, 0);
        idleCycles(4);

        // Start while busy is ignored
        applyStimulus(2, 6, 1'b1);
        applyStimulus(9, 3, 1'b0);
        waitDone(30);
        idleCycles(10);
        checkOutput("busy_ignored_idle", busy, 0);
        checkOutput("busy_ignored_queue", expQ.size(), 0);

        // Random bursts with random stalls
        randomReady = 1'b1;
        for (int n = 0; n < 6; n++) begin
            applyStimulus(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)), 1'b1);
            waitDone(300);
            idleCycles(int'($urandom_range(1, 3)));
        end
        randomReady = 1'b0;
        idleCycles(3);

        // Reset mid-burst
        b = beatCount;
        target = b + 3;
        applyStimulus(int'($urandom_range(0, DEPTH - 1)), 10, 1'b1);
        for (int i = 0; i < 50; i++) begin
            if (beatCount >= target) break;
            @(negedge clk);
        end
        checkOutput("mid_reset_beats", beatCount, target);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expQ.delete();
        lastSeen  = 1'b0;
        stallPrev = 1'b0;
        checkOutput("abort_valid", m_valid, 0);
        checkOutput("abort_data", m_data, 0);
        checkOutput("abort_last", m_last, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_addr", rom_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 2, 1'b1);
        waitDone(20);
        idleCycles(5);

        checkOutput("final_queue_empty", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rom_streamer.md
# rom_streamer

Read sequencer for the synchronous lookup ROM (Data_Width × 2^Addr_Width, one-cycle registered read). On a start pulse it walks a contiguous, wrapping address range, drives the ROM address port, and emits the returned words on a valid/ready stream with full backpressure support. It sits directly upstream of the ROM address input and downstream of its Dout, turning the ROM into a burst source for consumer logic.

## Interface
- Data_Width, 8, ROM word width and stream data width
- Addr_Width, 4, ROM address width; ROM depth = 2^Addr_Width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  Addr_Width  first address of the burst, sampled with start
- count  in  Addr_Width+1  number of words, 0 to 2^Addr_Width, sampled with start
- rom_addr  out  Addr_Width  registered address to the ROM
- rom_dout  in  Data_Width  ROM read data, valid one cycle after rom_addr is sampled
- m_data  out  Data_Width  stream data
- m_valid  out  1  stream data valid
- m_ready  in  1  consumer ready
- m_last  out  1  high with the final word of the burst
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the burst completes

## Operation
- Reset values: rom_addr=0, m_data=0, m_valid=0, m_last=0, busy=0, done=0, FSM=IDLE, FIFO empty, counters 0.
- FSM states:
  - IDLE: start=1 with count≠0 goes to FETCH, latches base_addr/count, sets rom_addr=base_addr, busy=1. start=1 with count=0 pulses done next cycle, stays IDLE, no beats.
  - FETCH: issues one ROM read per cycle while credit allows; goes to DRAIN after the last address is issued.
  - DRAIN: waits until all words are handed off, then pulses done and returns to IDLE with busy=0.
- Credit rule: a read issues only when FIFO occupancy plus in-flight reads < 2. This guarantees no word is ever lost under backpressure.
- Address arithmetic: rom_addr increments modulo 2^Addr_Width; a burst crossing the top address wraps to 0. For example, base=14, count=4 gives 14, 15, 0, 1.
- count=2^Addr_Width reads every location exactly once.
- The issued-word counter is Addr_Width+1 bits wide and never wraps.
- m_last is asserted only on the beat whose index is count-1.
- m_data/m_valid/m_last hold stable while m_valid=1 and m_ready=0.
- start while busy=1 is ignored, with no effect on the current burst.
- Asynchronous reset mid-burst aborts the burst: outputs return immediately to reset values and in-flight ROM data is discarded.

## Timing
- Start edge E0 (start sampled high):
  - after E0, rom_addr=base_addr;
  - at E1 the ROM samples the address;
  - at E2 the FIFO captures rom_dout;
  - after E2, m_valid=1.
- First-beat latency is 2 clocks from the start edge.
- With m_ready held high, throughput is 1 word per clock and a burst of N takes N+2 clocks to the last handshake.
- done pulses in the cycle after the clock edge that completes the m_last handshake. busy drops in that same cycle.
- A new start is accepted in the cycle done is high, since the FSM is already in IDLE.
- Backpressure release: the first m_ready=1 after a stall completes a handshake at that edge. Issue resumes at most 1 clock later.

## Structure
- Package rom_stream_pkg holds the FSM state enum (IDLE, FETCH, DRAIN) and the localparam FIFO_DEPTH=2.
- One sub-module, stream_fifo2: a 2-entry, Data_Width+1-bit (data + last) FIFO with push/pop, full/empty, and async active-low reset.
- The top level holds the FSM, the address and issue counters, the in-flight flag, and the credit logic.

## Test plan
- Reset, then start with base=3, count=5 and m_ready=1 → m_data = ROM[3..7] on 5 consecutive cycles, first m_valid 2 clocks after start, m_last on ROM[7], done one cycle later.
- Wrap: base=14, count=4 → rom_addr sequence 14, 15, 0, 1; data ROM[14], ROM[15], ROM[0], ROM[1].
- Backpressure: count=16 with m_ready toggling on a random pattern → all 16 words delivered in order, none dropped or duplicated, outputs stable during stalls, FIFO occupancy never above 2.
- Edge counts: count=0 → done next cycle, m_valid never high. A start during a busy burst → ignored, first burst unaffected.
- Reset mid-burst: assert rst_n=0 after 3 beats of a count=10 burst → outputs zero immediately. A new burst base=0, count=2 then returns ROM[0], ROM[1] only.
